// File: rtl/uart_rx_fifo_wr.sv
// 8N1 UART receiver that pushes each good byte into a downstream FIFO.
// Flags framing errors and bytes dropped because the FIFO was full.
module uart_rx_fifo_wr #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        full,
    output logic        wr,
    output logic [7:0]  din,
    output logic        frame_err,
    output logic        overrun,
    output logic [15:0] byte_cnt
);

    localparam logic [9:0] HALF_LAST = 10'(CLKS_PER_BIT / 2 - 1);
    localparam logic [9:0] BIT_LAST  = 10'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_t;

    state_t      r_state;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic        r_rx_prev;
    logic [9:0]  r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_din;
    logic        r_wr;
    logic        r_frame_err;
    logic        r_overrun;
    logic [15:0] r_byte_cnt;
    logic        w_fall;

    // r_rx_prev tracks rx_s independently of state, so an edge landing in the
    // cycle IDLE is re-entered is still seen.
    assign w_fall = r_rx_prev & ~r_rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_din       <= '0;
            r_wr        <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_byte_cnt  <= '0;
        end else begin
            r_rx_meta   <= rx;
            r_rx_s      <= r_rx_meta;
            r_rx_prev   <= r_rx_s;
            r_wr        <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (w_fall) begin
                        r_state <= StStart;
                        r_cnt   <= '0;
                    end
                end
                StStart: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_rx_s ? StIdle : StData;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                StData: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
                            r_state   <= StStop;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                StStop: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt <= '0;
                        r_din <= r_shift;
                        if (!r_rx_s) begin
                            r_frame_err <= 1'b1;
                            r_state     <= StBreak;
                        end else if (full) begin
                            r_overrun <= 1'b1;
                            r_state   <= StIdle;
                        end else begin
                            r_wr    <= 1'b1;
                            r_state <= StIdle;
                            if (r_byte_cnt != 16'hFFFF) begin
                                r_byte_cnt <= r_byte_cnt + 16'd1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                StBreak: begin
                    if (r_rx_s) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign wr        = r_wr;
    assign din       = r_din;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign byte_cnt  = r_byte_cnt;

endmodule

// File: tb/tb_uart_rx_fifo_wr.sv
// Directed bench for uart_rx_fifo_wr: serial frames driven bit by bit,
// output pulses counted by a monitor and checked with immediate assertions.
module tb_uart_rx_fifo_wr;

    localparam int CPB = 16;

    logic        clk;
    logic        rst;
    logic        rx;
    logic        full;
    logic        wr;
    logic [7:0]  din;
    logic        frame_err;
    logic        overrun;
    logic [15:0] byte_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int last_wr_cyc = 0;
    logic [7:0] wr_log[$];

    uart_rx_fifo_wr #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .full      (full),
        .wr        (wr),
        .din       (din),
        .frame_err (frame_err),
        .overrun   (overrun),
        .byte_cnt  (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulses are sampled mid-cycle; a pulse held two cycles counts twice.
    always @(negedge clk) begin
        if (wr) begin
            wr_cnt      <= wr_cnt + 1;
            last_wr_cyc <= cyc;
            wr_log.push_back(din);
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun)   ov_cnt <= ov_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; holds rx for one bit period.
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    initial begin
        int w0;
        int b0;
        int n0;
        int fall_cyc;
        int lat;
        logic [7:0] f0_bits;

        rst  = 1'b1;
        rx   = 1'b1;
        full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr", {31'b0, wr}, 32'd0);
        check("rst_frame_err", {31'b0, frame_err}, 32'd0);
        check("rst_overrun", {31'b0, overrun}, 32'd0);
        check("rst_din", {24'b0, din}, 32'h00);
        check("rst_byte_cnt", {16'b0, byte_cnt}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Good byte, FIFO has room
        w0 = wr_cnt;
        fall_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        drive_bit(1'b1);
        lat = last_wr_cyc - fall_cyc;
        check("a5_wr_pulses", 32'(wr_cnt - w0), 32'd1);
        check("a5_din", {24'b0, din}, 32'hA5);
        check("a5_byte_cnt", {16'b0, byte_cnt}, 32'd1);
        check("a5_latency_in_range", {31'b0, (lat >= 154 && lat <= 156)}, 32'd1);
        check("a5_no_frame_err", 32'(fe_cnt), 32'd0);
        check("a5_no_overrun", 32'(ov_cnt), 32'd0);

        // FIFO full: byte dropped
        full = 1'b1;
        send_frame(8'h3C, 1'b1);
        drive_bit(1'b1);
        full = 1'b0;
        check("3c_overrun", 32'(ov_cnt), 32'd1);
        check("3c_no_wr", 32'(wr_cnt), 32'd1);
        check("3c_byte_cnt", {16'b0, byte_cnt}, 32'd1);
        check("3c_din", {24'b0, din}, 32'h3C);

        // Stop bit low, line held in break, then recovery
        send_frame(8'h00, 1'b0);
        repeat (40) @(negedge clk);
        check("brk_frame_err", 32'(fe_cnt), 32'd1);
        check("brk_no_wr", 32'(wr_cnt), 32'd1);
        check("brk_no_overrun", 32'(ov_cnt), 32'd1);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h81, 1'b1);
        drive_bit(1'b1);
        check("81_wr", 32'(wr_cnt), 32'd2);
        check("81_din", {24'b0, din}, 32'h81);
        check("81_byte_cnt", {16'b0, byte_cnt}, 32'd2);
        check("81_frame_err_once", 32'(fe_cnt), 32'd1);

        // Short glitch is rejected
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_wr", 32'(wr_cnt), 32'd2);
        check("glitch_no_frame_err", 32'(fe_cnt), 32'd1);
        check("glitch_no_overrun", 32'(ov_cnt), 32'd1);

        // Back-to-back frames, single stop bit each
        b0 = int'(byte_cnt);
        n0 = wr_log.size();
        send_frame(8'h01, 1'b1);
        send_frame(8'hFE, 1'b1);
        send_frame(8'h55, 1'b1);
        drive_bit(1'b1);
        check("b2b_wr_count", 32'(wr_cnt), 32'd5);
        check("b2b_byte_cnt_delta", 32'(int'(byte_cnt) - b0), 32'd3);
        check("b2b_byte0", {24'b0, wr_log[n0]}, 32'h01);
        check("b2b_byte1", {24'b0, wr_log[n0 + 1]}, 32'hFE);
        check("b2b_byte2", {24'b0, wr_log[n0 + 2]}, 32'h55);

        // Reset in the middle of 0xF0 (during high bit 5), then 0x0F
        w0 = wr_cnt;
        f0_bits = 8'hF0;
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(f0_bits[i]);
        rx = f0_bits[5];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_byte_cnt", {16'b0, byte_cnt}, 32'd0);
        check("midrst_din", {24'b0, din}, 32'h00);
        rst = 1'b0;
        repeat (CPB / 2 - 2) @(negedge clk);
        drive_bit(f0_bits[6]);
        drive_bit(f0_bits[7]);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("midrst_no_wr", 32'(wr_cnt - w0), 32'd0);
        check("midrst_no_frame_err", 32'(fe_cnt), 32'd1);
        check("midrst_no_overrun", 32'(ov_cnt), 32'd1);
        send_frame(8'h0F, 1'b1);
        drive_bit(1'b1);
        check("0f_wr", 32'(wr_cnt - w0), 32'd1);
        check("0f_din", {24'b0, din}, 32'h0F);
        check("0f_byte_cnt", {16'b0, byte_cnt}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
